logic_gate_pipe: RTL and testbench
==================================

LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter SWEEP_EN, default 1; when 1 the built-in sweep generator exists, and when 0 sweep_start is ignored and sweep_busy stays 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered set this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port op, input, 3 bits: the operation select.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-011 The block SHALL have port y, output, WIDTH bits: the result.
REQ-012 The block SHALL have port op_out, output, 3 bits: the op that produced y.
REQ-013 The block SHALL have port red_and, output, 1 bit: reduction AND of y.
REQ-014 The block SHALL have port red_or, output, 1 bit: reduction OR of y.
REQ-015 The block SHALL have port red_xor, output, 1 bit: reduction XOR of y.
REQ-016 The block SHALL have port op_err, output, 1 bit: the result came from an illegal op.
REQ-017 The block SHALL have port sweep_start, input, 1 bit: a pulse requesting the exhaustive self-sweep.
REQ-018 The block SHALL have port sweep_busy, output, 1 bit: the sweep is generating or draining.
REQ-019 The block SHALL have port sweep_done, output, 1 bit: a one-cycle pulse when the sweep completes.

Function
REQ-020 Op encoding SHALL be: 0 NOT a; 1 AND; 2 OR; 3 NAND; 4 NOR; 5 XOR; 6 XNOR; 7 illegal, giving y=0 and op_err=1.
REQ-021 All ops SHALL be bitwise over WIDTH bits, with no carry and no width growth.
REQ-022 The datapath SHALL be two register stages (S1 captures a, b, op; S2 holds y, op_out, the reduction flags and op_err), each stage with its own valid bit.
REQ-023 Latency SHALL be exactly 2 cycles from an accepting edge to out_valid, given out_ready=1.
REQ-024 Throughput SHALL be one transaction per cycle under continuous in_valid and out_ready.
REQ-025 A stage SHALL advance when it is empty or when the stage after it advances.
REQ-026 in_ready SHALL equal (S1 empty or S1 advancing) AND NOT sweep_busy.
REQ-027 A transfer SHALL occur only on valid AND ready at a rising clk edge.
REQ-028 While out_valid=1 and out_ready=0, y, op_out, the flags and op_err SHALL hold stable.
REQ-029 A result SHALL never be dropped or duplicated under any backpressure pattern.
REQ-030 The sweep FSM SHALL have states IDLE, GEN and DRAIN.
REQ-031 In IDLE, sweep_start=1 SHALL move the FSM to GEN, with the op index and pattern index cleared.
REQ-032 A sweep_start arriving outside IDLE SHALL be ignored.
REQ-033 GEN SHALL inject the 28 transactions in the order op 0..6 outer, pattern 0..3 inner, where pattern 0 is a=0,b=0; pattern 1 is a=0,b=all-ones; pattern 2 is a=all-ones,b=0; pattern 3 is a=all-ones,b=all-ones.
REQ-034 GEN SHALL inject through the same S1 advance rule, so it stalls under backpressure.
REQ-035 After the 28th injection, the FSM SHALL move to DRAIN.
REQ-036 DRAIN SHALL last until S1 and S2 are both empty.
REQ-037 On leaving DRAIN, the FSM SHALL pulse sweep_done for one cycle and return to IDLE.
REQ-038 sweep_busy SHALL be 1 in GEN and DRAIN.
REQ-039 An external in_valid during sweep_busy SHALL be not accepted and SHALL cause no side effect.
REQ-040 An in-flight external transaction at sweep_start SHALL complete normally, ahead of the sweep results.
REQ-041 When sweep_start and an in_valid handshake occur in the same cycle, the external transaction SHALL be accepted and the sweep SHALL start on the next cycle.

Reset
REQ-042 rst=1 SHALL asynchronously clear both stage valid bits, out_valid, sweep_done, sweep_busy and op_err.
REQ-043 rst=1 SHALL asynchronously clear y, op_out and all reduction flags to 0, and return the FSM to IDLE with its counters at 0.
REQ-044 A reset asserted mid-sweep or mid-transfer SHALL discard all in-flight data, and no sweep_done SHALL follow.
REQ-045 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after release.

Structure
REQ-046 The op code localparams (OP_NOT..OP_XNOR, OP_ILL), the FSM state encoding and the sweep length 28 SHALL live in shared package logic_gate_pkg.
REQ-047 Combinational op evaluation SHALL be one sub-module, gate_eval (a, b, op -> y, op_err), instantiated once in the S2 path.

Verification
REQ-048 The bench SHALL drive WIDTH=8, op=1, a=8'hF0, b=8'h3C with out_ready=1, and SHALL check y=8'h30, red_or=1, red_and=0 and red_xor=0 two cycles after acceptance.
REQ-049 The bench SHALL drive op=7 with any operands, and SHALL check y=0, op_err=1 and op_out=7.
REQ-050 The bench SHALL drive 10 back-to-back transactions while holding out_ready=0 for cycles 3..6, and SHALL check that in_ready drops after both stages fill, that y stays stable while stalled, and that all 10 results arrive in order.
REQ-051 The bench SHALL pulse sweep_start with out_ready=1, and SHALL check 28 results matching the truth table per op and pattern (for example op 5, pattern 1 gives y=8'hFF), followed by sweep_done exactly once, with in_ready=0 throughout.
REQ-052 The bench SHALL assert rst after the 10th sweep result, and SHALL check that out_valid, sweep_busy and y drop to 0 immediately with no sweep_done.
REQ-053 The bench SHALL repeat the sweep with WIDTH=1 and check that the results reproduce the 2-input truth table for all seven gates.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared op codes, sweep FSM state encoding and sweep sizing for the
// logic gate pipeline.
package logic_gate_pkg;

   localparam logic [2:0] OP_NOT  = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_XNOR = 3'd6;
   localparam logic [2:0] OP_ILL  = 3'd7;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GEN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Seven legal ops times four corner patterns; index = op*4 + pattern.
   localparam int SWEEP_LEN   = 28;
   localparam int SWEEP_CNT_W = $clog2(SWEEP_LEN);

endpackage

// File: rtl/logic_gate_pipe_gate_eval.sv
// Combinational evaluation of one bitwise gate op; illegal codes give zero
// with op_err raised.
module gate_eval
   import logic_gate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             op_err
);

   always_comb begin
      y      = '0;
      op_err = 1'b0;
      case (op)
         OP_NOT:  y = ~a;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         default: op_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage bitwise logic-gate pipeline with valid/ready handshake and a
// built-in exhaustive sweep generator that injects through the front stage.
module logic_gate_pipe
   import logic_gate_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int SWEEP_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [2:0]       op_out,
   output logic             red_and,
   output logic             red_or,
   output logic             red_xor,
   output logic             op_err,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done
);

   logic [1:0]             state;
   logic [SWEEP_CNT_W-1:0] sweep_idx;
   logic                   adv_p1;
   logic                   adv_p2;
   logic                   src_vld;
   logic [WIDTH-1:0]       src_a;
   logic [WIDTH-1:0]       src_b;
   logic [2:0]             src_op;
   logic                   vld_p1;
   logic [WIDTH-1:0]       a_p1;
   logic [WIDTH-1:0]       b_p1;
   logic [2:0]             op_p1;
   logic [WIDTH-1:0]       eval_y;
   logic                   eval_err;
   logic                   vld_p2;
   logic [WIDTH-1:0]       y_p2;
   logic [2:0]             op_p2;
   logic                   red_and_p2;
   logic                   red_or_p2;
   logic                   red_xor_p2;
   logic                   err_p2;
   logic                   done_r;

   assign sweep_busy = (state != ST_IDLE);
   assign adv_p2     = !vld_p2 || out_ready;
   assign adv_p1     = !vld_p1 || adv_p2;
   assign in_ready   = adv_p1 && !sweep_busy && !rst;

   // The sweep generator takes over the front stage while in GEN; external
   // offers are simply not accepted while the sweep is busy.
   always_comb begin
      src_vld = in_valid && !sweep_busy;
      src_a   = a;
      src_b   = b;
      src_op  = op;
      if (state == ST_GEN) begin
         src_vld = 1'b1;
         src_op  = sweep_idx[SWEEP_CNT_W-1:2];
         src_a   = {WIDTH{sweep_idx[1]}};
         src_b   = {WIDTH{sweep_idx[0]}};
      end
   end

   // ---- stage 1: capture operands and op ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (adv_p1) begin
         vld_p1 <= src_vld;
      end
   end

   always_ff @(posedge clk) begin
      if (adv_p1 && src_vld) begin
         a_p1  <= src_a;
         b_p1  <= src_b;
         op_p1 <= src_op;
      end
   end

   gate_eval #(.WIDTH(WIDTH)) u_gate_eval (
      .a      (a_p1),
      .b      (b_p1),
      .op     (op_p1),
      .y      (eval_y),
      .op_err (eval_err)
   );

   // ---- stage 2: result, op tag and reduction flags ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2     <= 1'b0;
         y_p2       <= '0;
         op_p2      <= 3'd0;
         red_and_p2 <= 1'b0;
         red_or_p2  <= 1'b0;
         red_xor_p2 <= 1'b0;
         err_p2     <= 1'b0;
      end else if (adv_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            y_p2       <= eval_y;
            op_p2      <= op_p1;
            red_and_p2 <= &eval_y;
            red_or_p2  <= |eval_y;
            red_xor_p2 <= ^eval_y;
            err_p2     <= eval_err;
         end
      end
   end

   assign out_valid  = vld_p2;
   assign y          = y_p2;
   assign op_out     = op_p2;
   assign red_and    = red_and_p2;
   assign red_or     = red_or_p2;
   assign red_xor    = red_xor_p2;
   assign op_err     = err_p2;
   assign sweep_done = done_r;

   // Sweep FSM: the index advances only when the front stage takes the
   // injected pattern, so backpressure stalls generation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         sweep_idx <= '0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (SWEEP_EN != 0 && sweep_start) begin
                  state     <= ST_GEN;
                  sweep_idx <= '0;
               end
            end
            ST_GEN: begin
               if (adv_p1) begin
                  if (sweep_idx == SWEEP_CNT_W'(SWEEP_LEN - 1)) begin
                     state     <= ST_DRAIN;
                     sweep_idx <= '0;
                  end else begin
                     sweep_idx <= sweep_idx + SWEEP_CNT_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (!vld_p1 && !vld_p2) begin
                  state  <= ST_IDLE;
                  done_r <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: WIDTH=8 and WIDTH=1 instances checked
// against a truth-table reference model.
module tb_logic_gate_pipe;

   typedef struct packed {
      logic [63:0] y;
      logic [2:0]  op;
      logic        ra;
      logic        ro;
      logic        rx;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic       rst8, iv8, ir8, ov8, or8, ss8, sb8, sd8, ra8, ro8, rx8, er8;
   logic [7:0] a8, b8, y8;
   logic [2:0] op8, oo8;
   logic       rst1, iv1, ir1, ov1, or1, ss1, sb1, sd1, ra1, ro1, rx1, er1;
   logic [0:0] a1, b1, y1;
   logic [2:0] op1, oo1;

   exp_t        q8[$];
   exp_t        q1[$];
   logic [63:0] log8[$];
   logic [63:0] log1[$];
   int          done8 = 0;
   int          done1 = 0;

   logic_gate_pipe #(.WIDTH(8), .SWEEP_EN(1)) dut8 (
      .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
      .out_valid(ov8), .out_ready(or8), .y(y8), .op_out(oo8), .red_and(ra8), .red_or(ro8),
      .red_xor(rx8), .op_err(er8), .sweep_start(ss8), .sweep_busy(sb8), .sweep_done(sd8));

   logic_gate_pipe #(.WIDTH(1), .SWEEP_EN(1)) dut1 (
      .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .op(op1),
      .out_valid(ov1), .out_ready(or1), .y(y1), .op_out(oo1), .red_and(ra1), .red_or(ro1),
      .red_xor(rx1), .op_err(er1), .sweep_start(ss1), .sweep_busy(sb1), .sweep_done(sd1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [63:0] ones_of(input int w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

   // Per-bit truth table indexed by {a_bit, b_bit}; flags from a population count.
   function automatic exp_t model(input int w, input logic [2:0] op,
                                  input logic [63:0] a, input logic [63:0] b);
      exp_t       r;
      logic [3:0] tt;
      int         n;
      r     = '0;
      r.op  = op;
      r.err = (op == 3'd7);
      case (op)
         3'd0:    tt = 4'b0011;
         3'd1:    tt = 4'b1000;
         3'd2:    tt = 4'b1110;
         3'd3:    tt = 4'b0111;
         3'd4:    tt = 4'b0001;
         3'd5:    tt = 4'b0110;
         3'd6:    tt = 4'b1001;
         default: tt = 4'b0000;
      endcase
      n = 0;
      for (int i = 0; i < w; i++) begin
         r.y[i] = tt[{a[i], b[i]}];
         if (r.y[i]) n++;
      end
      r.ra = (n == w);
      r.ro = (n > 0);
      r.rx = ((n % 2) == 1);
      return r;
   endfunction

   function automatic exp_t sweep_exp(input int w, input int k);
      int p;
      p = k % 4;
      return model(w, 3'(k / 4), (p >= 2) ? ones_of(w) : 64'd0,
                   (p == 1 || p == 3) ? ones_of(w) : 64'd0);
   endfunction

   // Monitor / scoreboard for the WIDTH=8 instance.
   always @(negedge clk) begin
      if (!rst8) begin
         if (ov8) begin
            if (q8.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL out8_unexpected actual_y=%0h required=no_result", y8);
            end else begin
               chk("y8", 64'(y8), q8[0].y);
               chk("op_out8", 64'(oo8), 64'(q8[0].op));
               chk("flags8", 64'({ra8, ro8, rx8, er8}),
                   64'({q8[0].ra, q8[0].ro, q8[0].rx, q8[0].err}));
               if (or8) begin
                  void'(q8.pop_front());
                  log8.push_back(64'(y8));
               end
            end
         end
         if (iv8 && ir8) q8.push_back(model(8, op8, 64'(a8), 64'(b8)));
         if (ss8 && !sb8) for (int k = 0; k < 28; k++) q8.push_back(sweep_exp(8, k));
         if (sb8) chk("in_ready_busy8", 64'(ir8), 64'd0);
         if (sd8) done8++;
      end
   end

   // Monitor / scoreboard for the WIDTH=1 instance.
   always @(negedge clk) begin
      if (!rst1) begin
         if (ov1) begin
            if (q1.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL out1_unexpected actual_y=%0h required=no_result", y1);
            end else begin
               chk("y1", 64'(y1), q1[0].y);
               chk("op_out1", 64'(oo1), 64'(q1[0].op));
               chk("flags1", 64'({ra1, ro1, rx1, er1}),
                   64'({q1[0].ra, q1[0].ro, q1[0].rx, q1[0].err}));
               if (or1) begin
                  void'(q1.pop_front());
                  log1.push_back(64'(y1));
               end
            end
         end
         if (iv1 && ir1) q1.push_back(model(1, op1, 64'(a1), 64'(b1)));
         if (ss1 && !sb1) for (int k = 0; k < 28; k++) q1.push_back(sweep_exp(1, k));
         if (sb1) chk("in_ready_busy1", 64'(ir1), 64'd0);
         if (sd1) done1++;
      end
   end

   task automatic drain8();
      @(posedge clk); #1;
      iv8 = 1'b0; or8 = 1'b1; ss8 = 1'b0;
      for (int k = 0; k < 300 && (q8.size() != 0 || sb8); k++) @(posedge clk);
      #1;
      chk("drain8_empty", 64'(q8.size()), 64'd0);
      chk("drain8_idle", 64'(sb8), 64'd0);
   endtask

   task automatic drain1();
      @(posedge clk); #1;
      iv1 = 1'b0; or1 = 1'b1; ss1 = 1'b0;
      for (int k = 0; k < 300 && (q1.size() != 0 || sb1); k++) @(posedge clk);
      #1;
      chk("drain1_empty", 64'(q1.size()), 64'd0);
      chk("drain1_idle", 64'(sb1), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   s;
      int   d0;
      int   idx;
      int   p;
      logic ea, eb, e;

      rst8 = 1'b1; iv8 = 1'b0; ss8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;
      rst1 = 1'b1; iv1 = 1'b0; ss1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; op1 = '0;
      #2;
      chk("rst_out_valid8", 64'(ov8), 64'd0);
      chk("rst_y8", 64'(y8), 64'd0);
      chk("rst_op_out8", 64'(oo8), 64'd0);
      chk("rst_busy8", 64'(sb8), 64'd0);
      chk("rst_in_ready8", 64'(ir8), 64'd0);
      chk("rst_flags8", 64'({ra8, ro8, rx8, er8, sd8}), 64'd0);
      chk("rst_out_valid1", 64'(ov1), 64'd0);
      repeat (2) @(posedge clk);
      #1; rst8 = 1'b0; rst1 = 1'b0;
      @(negedge clk);
      chk("in_ready_release8", 64'(ir8), 64'd1);
      chk("in_ready_release1", 64'(ir1), 64'd1);

      // AND of F0 and 3C, two-cycle latency
      @(posedge clk); #1;
      iv8 = 1'b1; op8 = 3'd1; a8 = 8'hF0; b8 = 8'h3C;
      @(negedge clk);
      chk("accept_and8", 64'(ir8), 64'd1);
      @(posedge clk); #1; iv8 = 1'b0;
      @(negedge clk);
      chk("latency_c1_out_valid8", 64'(ov8), 64'd0);
      @(negedge clk);
      chk("latency_c2_out_valid8", 64'(ov8), 64'd1);
      chk("and_y8", 64'(y8), 64'h30);
      chk("and_red_or8", 64'(ro8), 64'd1);
      chk("and_red_and8", 64'(ra8), 64'd0);
      chk("and_red_xor8", 64'(rx8), 64'd0);

      // illegal op
      @(posedge clk); #1;
      iv8 = 1'b1; op8 = 3'd7; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1; iv8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ill_out_valid8", 64'(ov8), 64'd1);
      chk("ill_y8", 64'(y8), 64'd0);
      chk("ill_op_err8", 64'(er8), 64'd1);
      chk("ill_op_out8", 64'(oo8), 64'd7);
      drain8();

      // ten back-to-back with out_ready low in cycles 3..6
      s = log8.size();
      idx = 0;
      for (int c = 0; c < 60 && idx < 10; c++) begin
         @(posedge clk); #1;
         or8 = !(c >= 3 && c <= 6);
         iv8 = 1'b1;
         op8 = 3'($urandom_range(0, 6)); a8 = 8'($urandom); b8 = 8'($urandom);
         @(negedge clk);
         if (c >= 3 && c <= 6) chk("in_ready_full8", 64'(ir8), 64'd0);
         if (iv8 && ir8) idx++;
      end
      drain8();
      chk("burst_count8", 64'(log8.size() - s), 64'd10);

      // random traffic with random backpressure
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         iv8 = ($urandom_range(0, 3) != 0);
         op8 = 3'($urandom_range(0, 7)); a8 = 8'($urandom); b8 = 8'($urandom);
         or8 = ($urandom_range(0, 3) != 0);
      end
      drain8();

      // sweep with external offers and a repeated start while busy
      @(posedge clk); #1;
      ss8 = 1'b1; or8 = 1'b1; s = log8.size(); d0 = done8;
      @(posedge clk); #1; ss8 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         iv8 = 1'b1; op8 = 3'($urandom_range(0, 7)); a8 = 8'($urandom); b8 = 8'($urandom);
         ss8 = (c == 5);
      end
      drain8();
      repeat (5) @(posedge clk);
      #1;
      chk("sweep_results8", 64'(log8.size() - s), 64'd28);
      chk("sweep_done_once8", 64'(done8 - d0), 64'd1);
      if (log8.size() >= s + 28) chk("sweep_op5_p1_y8", log8[s + 21], 64'hFF);

      // sweep_start with a same-cycle external handshake, under backpressure
      @(posedge clk); #1;
      ss8 = 1'b1; iv8 = 1'b1; op8 = 3'd5; a8 = 8'($urandom); b8 = 8'($urandom);
      s = log8.size(); d0 = done8;
      @(negedge clk);
      chk("same_cycle_accept8", 64'(ir8), 64'd1);
      @(posedge clk); #1; ss8 = 1'b0; iv8 = 1'b0;
      @(negedge clk);
      chk("sweep_busy_next8", 64'(sb8), 64'd1);
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         or8 = ($urandom_range(0, 2) != 0);
      end
      drain8();
      repeat (3) @(posedge clk);
      #1;
      chk("sweep_bp_results8", 64'(log8.size() - s), 64'd29);
      chk("sweep_bp_done_once8", 64'(done8 - d0), 64'd1);

      // reset after the tenth sweep result
      @(posedge clk); #1;
      ss8 = 1'b1; or8 = 1'b1; s = log8.size(); d0 = done8;
      @(posedge clk); #1; ss8 = 1'b0;
      for (int k = 0; k < 200 && (log8.size() - s) < 10; k++) @(posedge clk);
      chk("reset_point8", 64'(log8.size() - s), 64'd10);
      #1; rst8 = 1'b1; q8.delete();
      #1;
      chk("rst_mid_out_valid8", 64'(ov8), 64'd0);
      chk("rst_mid_busy8", 64'(sb8), 64'd0);
      chk("rst_mid_y8", 64'(y8), 64'd0);
      @(negedge clk);
      chk("rst_mid_in_ready8", 64'(ir8), 64'd0);
      @(posedge clk); #1; rst8 = 1'b0;
      @(negedge clk);
      chk("rst_release_in_ready8", 64'(ir8), 64'd1);
      repeat (40) @(posedge clk);
      #1;
      chk("no_done_after_rst8", 64'(done8 - d0), 64'd0);
      chk("no_results_after_rst8", 64'(log8.size() - s), 64'd10);

      // WIDTH=1: random traffic, then the sweep against the gate truth table
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         iv1 = ($urandom_range(0, 2) != 0);
         op1 = 3'($urandom_range(0, 7)); a1 = 1'($urandom); b1 = 1'($urandom);
         or1 = ($urandom_range(0, 3) != 0);
      end
      drain1();
      @(posedge clk); #1;
      ss1 = 1'b1; or1 = 1'b1; s = log1.size(); d0 = done1;
      @(posedge clk); #1; ss1 = 1'b0;
      drain1();
      repeat (3) @(posedge clk);
      #1;
      chk("sweep_results1", 64'(log1.size() - s), 64'd28);
      chk("sweep_done_once1", 64'(done1 - d0), 64'd1);
      if (log1.size() >= s + 28) begin
         for (int k = 0; k < 28; k++) begin
            p  = k % 4;
            ea = (p >= 2);
            eb = (p == 1 || p == 3);
            case (k / 4)
               0:       e = !ea;
               1:       e = ea && eb;
               2:       e = ea || eb;
               3:       e = !(ea && eb);
               4:       e = !(ea || eb);
               5:       e = ea ^ eb;
               default: e = !(ea ^ eb);
            endcase
            chk($sformatf("truth1_op%0d_p%0d", k / 4, p), log1[s + k], 64'(e));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
